// File: rtl/btn_pkg.sv
// Shared definitions for the push-button reader: FSM state encoding, default timing
// constants and the millisecond-to-cycle conversion used to size the counters.
package btn_pkg;

    typedef enum logic [1:0] {
        StRel = 2'd0,
        StPrs = 2'd1,
        StHld = 2'd2
    } btn_state_e;

    localparam int unsigned DefClkFreq   = 27000000;
    localparam int unsigned DefNumBtn    = 2;
    localparam int unsigned DefDebounceMs = 10;
    localparam int unsigned DefLongMs    = 1000;
    localparam int unsigned DefRepeatMs  = 200;

    // Divide first so large clock frequencies do not overflow 32 bits.
    function automatic int unsigned ms_to_cyc(input int unsigned clk_freq, input int unsigned ms);
        return clk_freq / 1000 * ms;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchronizer, debounce counter, press/hold FSM and registered
// event pulses. Define BTN_REPEAT_EN to make long_pulse auto-repeat while the button is held.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DbCyc   = 4,
    parameter int unsigned LongCyc = 20
`ifdef BTN_REPEAT_EN
    ,
    parameter int unsigned RepCyc  = 5
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned DbW   = $clog2(DbCyc + 1);
    localparam int unsigned HoldW = $clog2(LongCyc + 1);
    localparam logic [DbW-1:0]   DbLast   = DbW'(DbCyc - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LongCyc - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    btn_state_e       state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;

`ifdef BTN_REPEAT_EN
    localparam int unsigned RepW = $clog2(RepCyc + 1);
    localparam logic [RepW-1:0] RepLast = RepW'(RepCyc - 1);

    logic [RepW-1:0] rep_q, rep_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    // Accept a level change only after it has been seen DbCyc cycles in a row.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DbLast) begin
                stable_d = ~stable_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
`ifdef BTN_REPEAT_EN
        rep_d     = '0;
`endif
        case (state_q)
            StRel: begin
                hold_d = '0;
                if (stable_q) begin
                    state_d = StPrs;
                    press_d = 1'b1;
                end
            end
            StPrs: begin
                // Release is checked first so it wins over a coincident long-press.
                if (!stable_q) begin
                    state_d   = StRel;
                    release_d = 1'b1;
                end else if (hold_q == HoldLast) begin
                    state_d = StHld;
                    long_d  = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StHld: begin
                if (!stable_q) begin
                    state_d   = StRel;
                    release_d = 1'b1;
                end
`ifdef BTN_REPEAT_EN
                else if (rep_q == RepLast) begin
                    long_d = 1'b1;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
`else
                // Without auto-repeat the hold state simply waits for release.
`endif
            end
            default: begin
                state_d = StRel;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= StRel;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= ~btn;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign pressed       = (state_q != StRel);
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule

// File: rtl/btn_reader.sv
// Reads NUM_BTN active-low push buttons and turns each into a debounced active-high level plus
// press/release/long-press pulses. Define BTN_REPEAT_EN to auto-repeat long_pulse while held.
module btn_reader
    import btn_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = DefClkFreq,
    parameter int unsigned NUM_BTN     = DefNumBtn,
    parameter int unsigned DEBOUNCE_MS = DefDebounceMs,
    parameter int unsigned LONG_MS     = DefLongMs,
    parameter int unsigned REPEAT_MS   = DefRepeatMs
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] pressed,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_pulse
);

    localparam int unsigned DbCyc   = ms_to_cyc(CLK_FREQ, DEBOUNCE_MS);
    localparam int unsigned LongCyc = ms_to_cyc(CLK_FREQ, LONG_MS);
`ifdef BTN_REPEAT_EN
    localparam int unsigned RepCyc  = ms_to_cyc(CLK_FREQ, REPEAT_MS);
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_debounce #(
            .DbCyc  (DbCyc),
            .LongCyc(LongCyc)
`ifdef BTN_REPEAT_EN
            ,
            .RepCyc (RepCyc)
`endif
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .btn          (btn[i]),
            .pressed      (pressed[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .long_pulse   (long_pulse[i])
        );
    end

endmodule

// File: doc/btn_reader.md
# btn_reader

Input-side companion to the LED drivers: samples the on-board active-low push buttons, synchronizes and debounces them, and turns each into clean, active-high levels and single-cycle event pulses (press, release, long-press). It sits between the raw button pins and any control logic that steps counters or modes, so downstream blocks never see metastable or bouncing inputs.

## Interface
- `CLK_FREQ`, 27000000: clock frequency in Hz.
- `NUM_BTN`, 2: number of button channels.
- `DEBOUNCE_MS`, 10: time the input must be stable before a level change is accepted.
- `LONG_MS`, 1000: hold time before a long-press event fires.
- `REPEAT_MS`, 200: auto-repeat period. Used only with `BTN_REPEAT_EN`.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn`  in  NUM_BTN  raw button pins, active-low (0 = pressed), asynchronous to `clk`.
- `pressed`  out  NUM_BTN  debounced level, 1 = held.
- `press_pulse`  out  NUM_BTN  one-cycle pulse on accepted press.
- `release_pulse`  out  NUM_BTN  one-cycle pulse on accepted release.
- `long_pulse`  out  NUM_BTN  one-cycle pulse when hold reaches `LONG_MS`. Also carries repeat pulses when `BTN_REPEAT_EN` is defined.

## Operation
- Derived constants:
  - `DB_CYC = CLK_FREQ/1000*DEBOUNCE_MS`.
  - `LONG_CYC = CLK_FREQ/1000*LONG_MS`.
  - `REP_CYC = CLK_FREQ/1000*REPEAT_MS`.
  - Each counter is `$clog2(max+1)` bits wide. Counters never wrap; they saturate or are cleared.
- Per channel, fully independent:
  - **Synchronizer:** a 2-FF synchronizer inverts `btn` to active-high.
  - **Debounce:** a counter increments every cycle the synced value differs from the accepted stable value. It clears to 0 on any cycle where they are equal.
  - **Acceptance:** when the counter reaches `DB_CYC-1` while still differing, the stable value flips on the next edge and the counter clears.
- FSM per channel:
  - **REL:** stable = 0. On stable flip to 1, go to PRS, clear the hold counter, and assert `press_pulse`.
  - **PRS:** the hold counter increments each cycle. When it reaches `LONG_CYC-1`, go to HLD and assert `long_pulse`. On stable flip to 0, go to REL and assert `release_pulse`.
  - **HLD:** on stable flip to 0, go to REL and assert `release_pulse`. The hold counter is idle, or repeats with `BTN_REPEAT_EN`.
- `pressed` = 1 in PRS and HLD, 0 in REL.
- Pulses are registered outputs: each is high for exactly one cycle per event.
- At most one pulse type fires per channel per cycle.
- **Release vs. long on the same cycle:** release wins; no `long_pulse` fires.
- A bounce shorter than `DB_CYC` cycles produces no output change.

## Timing
- **Reset:**
  - Synchronizer FFs reset to released (0 after inversion), stable = 0, state = REL, all counters = 0.
  - All outputs are 0 during and immediately after reset.
  - A button held through reset deassertion is accepted as a fresh press after the normal debounce latency.
- **Press latency:** from the first clock edge sampling `btn` low to `pressed`/`press_pulse` high is 2 (sync) + `DB_CYC` cycles, provided `btn` stays low. Release latency is identical.
- **Long latency:** `long_pulse` fires exactly `LONG_CYC` cycles after the `press_pulse` cycle.
- **Reset mid-operation:** asynchronous reset clears immediately, including any in-flight pulse.

## Configuration
- **`BTN_REPEAT_EN` defined:**
  - In HLD, the repeat counter counts to `REP_CYC-1`, then `long_pulse` fires for one cycle and the counter clears.
  - Repeats continue until release; release clears the counter.
- **`BTN_REPEAT_EN` undefined:** HLD emits no further pulses and the repeat counter logic is absent. `REPEAT_MS` is ignored.

## Structure
- **Shared package `btn_pkg`:**
  - FSM state encoding: REL = 2'd0, PRS = 2'd1, HLD = 2'd2.
  - `ms_to_cyc` constant function.
  - Default timing constants.
- **Sub-module `btn_debounce`:** one channel, consisting of synchronizer, debounce, FSM and pulse generation. `btn_reader` instantiates `NUM_BTN` copies via generate and concatenates the outputs.

## Test plan
Bench parameters: `CLK_FREQ` = 1000, `DEBOUNCE_MS` = 4, `LONG_MS` = 20, `REPEAT_MS` = 5, so `DB_CYC` = 4, `LONG_CYC` = 20, `REP_CYC` = 5.
- **Reset:** assert `rst_n` = 0 with `btn` = 2'b00 -> all outputs 0. Release reset, hold `btn[0]` low -> `press_pulse[0]` exactly 6 cycles after the first sample.
- **Clean press/release:** hold `btn[0]` low for 10 cycles, then high.
  - `press_pulse[0]` at cycle 6, `pressed[0]` high for 10 cycles.
  - `release_pulse[0]` 6 cycles after the rising edge.
  - `long_pulse[0]` never fires.
- **Bounce:** toggle `btn[1]` low 3 cycles / high 1 cycle ×5, then hold low -> exactly one `press_pulse[1]`, 6 cycles after the final falling edge.
- **Long press:** hold `btn[0]` low for 40 cycles -> `long_pulse[0]` 20 cycles after `press_pulse[0]`.
  - With `BTN_REPEAT_EN`: further pulses at +5, +10, +15 cycles until release.
  - Without `BTN_REPEAT_EN`: no further pulses.
- **Release on the long boundary:** time the release so that stable flips to 0 on the cycle the hold counter would reach 19 -> `release_pulse` only, no `long_pulse`.
- **Independence:** overlapping presses on both buttons, offset by 3 cycles -> each channel's pulses are offset by 3 cycles, with no cross-talk.
